// File: rtl/dff_checker.sv
// dff_checker: self-checking monitor for a single-bit D flip-flop with an
// asynchronous active-low clear. It predicts Q from the D and reset values
// seen at the previous clock edge. It counts checks and mismatches, and it
// records the index of the first mismatch.
module dff_checker #(
    parameter int CNT_W        = 16,
    parameter int NUM_CHECKS   = 100,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_d,
    input  logic             dut_rst_n,
    input  logic             dut_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail_pulse,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_err_vld,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CHK = CNT_W'(NUM_CHECKS);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state, state_nxt;
    logic             d_prev, d_prev_nxt;
    logic             rst_prev, rst_prev_nxt;
    logic [CNT_W-1:0] chk_nxt, err_nxt, idx_nxt;
    logic             vld_nxt, fp_nxt;
    logic             busy_nxt, done_nxt, pass_nxt;
    logic             exp_q, mismatch;

    // Reference model: Q is 0 while the clear is low now. It is also 0 on
    // the first edge after the clear is released, because the flop has not
    // clocked yet. Otherwise Q equals the D value seen at the previous edge.
    always_comb begin
        if (!dut_rst_n)     exp_q = 1'b0;
        else if (!rst_prev) exp_q = 1'b0;
        else                exp_q = d_prev;
        mismatch = (dut_q != exp_q);
    end

    // Next-state, counter and output decode for the run sequencer.
    always_comb begin
        // NOTE: every variable gets a default here first. An incomplete
        // assignment in a combinational block would infer a latch.
        state_nxt    = state;
        d_prev_nxt   = d_prev;
        rst_prev_nxt = rst_prev;
        chk_nxt      = chk_cnt;
        err_nxt      = err_cnt;
        idx_nxt      = first_err_idx;
        vld_nxt      = first_err_vld;
        fp_nxt       = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = PRIME;
                    chk_nxt   = '0;
                    err_nxt   = '0;
                    idx_nxt   = '0;
                    vld_nxt   = 1'b0;
                end
            end
            PRIME: begin
                d_prev_nxt   = dut_d;
                rst_prev_nxt = dut_rst_n;
                state_nxt    = RUN;
            end
            RUN: begin
                d_prev_nxt   = dut_d;
                rst_prev_nxt = dut_rst_n;
                chk_nxt      = chk_cnt + 1'b1;
                if (mismatch) begin
                    fp_nxt = 1'b1;
                    if (err_cnt != CNT_MAX) err_nxt = err_cnt + 1'b1;
                    if (!first_err_vld) begin
                        vld_nxt = 1'b1;
                        idx_nxt = chk_cnt;
                    end
                end
                if ((chk_nxt == LAST_CHK) || ((STOP_ON_FAIL != 0) && mismatch))
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt == PRIME) || (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
        pass_nxt = (state_nxt == DONE) && (err_nxt == '0);
    end

    // State, shadow and output registers. Reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            d_prev        <= 1'b0;
            rst_prev      <= 1'b0;
            chk_cnt       <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
            fail_pulse    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so all registers update together
            // from values taken before the edge.
            state         <= state_nxt;
            d_prev        <= d_prev_nxt;
            rst_prev      <= rst_prev_nxt;
            chk_cnt       <= chk_nxt;
            err_cnt       <= err_nxt;
            first_err_idx <= idx_nxt;
            first_err_vld <= vld_nxt;
            fail_pulse    <= fp_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            pass          <= pass_nxt;
        end
    end

endmodule

// File: tb/tb_dff_checker.sv
// tb_dff_checker: directed bench for dff_checker. A behavioural flop with an
// asynchronous clear produces the correct Q. Per-instance controls can force
// Q stuck at 0 or invert it for one chosen check. Three instances cover the
// default configuration, stop-on-first-failure, and a 4-bit counter width.
module tb_dff_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, dut_d, dut_rst_n, model_q;
    logic start_v[3], stuck_v[3], flip_v[3], q_v[3];
    logic busy_v[3], done_v[3], pass_v[3], fp_v[3], vld_v[3];
    logic [15:0] chk_v[3], err_v[3], idx_v[3];

    logic busy_a, done_a, pass_a, fp_a, vld_a;
    logic busy_b, done_b, pass_b, fp_b, vld_b;
    logic busy_c, done_c, pass_c, fp_c, vld_c;
    logic [15:0] chk_a, err_a, idx_a, chk_b, err_b, idx_b;
    logic [3:0]  chk_c, err_c, idx_c;

    int n_checks = 0;
    int n_err    = 0;

    // Correct flop: async clear, captures D on the rising edge.
    always_ff @(posedge clk or negedge dut_rst_n) begin
        if (!dut_rst_n) model_q <= 1'b0;
        else            model_q <= dut_d;
    end

    // Per-instance Q: correct, stuck at 0, or inverted for one check.
    always_comb begin
        for (int i = 0; i < 3; i++)
            q_v[i] = stuck_v[i] ? 1'b0 : (model_q ^ flip_v[i]);
    end

    // Gather instance outputs into arrays so the tasks can select an instance by index.
    always_comb begin
        busy_v[0] = busy_a; done_v[0] = done_a; pass_v[0] = pass_a; fp_v[0] = fp_a; vld_v[0] = vld_a;
        busy_v[1] = busy_b; done_v[1] = done_b; pass_v[1] = pass_b; fp_v[1] = fp_b; vld_v[1] = vld_b;
        busy_v[2] = busy_c; done_v[2] = done_c; pass_v[2] = pass_c; fp_v[2] = fp_c; vld_v[2] = vld_c;
        chk_v[0] = chk_a; err_v[0] = err_a; idx_v[0] = idx_a;
        chk_v[1] = chk_b; err_v[1] = err_b; idx_v[1] = idx_b;
        chk_v[2] = {12'd0, chk_c}; err_v[2] = {12'd0, err_c}; idx_v[2] = {12'd0, idx_c};
    end

    dff_checker #(.CNT_W(16), .NUM_CHECKS(100), .STOP_ON_FAIL(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .dut_d(dut_d), .dut_rst_n(dut_rst_n),
        .dut_q(q_v[0]), .busy(busy_a), .done(done_a), .pass(pass_a), .fail_pulse(fp_a),
        .chk_cnt(chk_a), .err_cnt(err_a), .first_err_vld(vld_a), .first_err_idx(idx_a));

    dff_checker #(.CNT_W(16), .NUM_CHECKS(100), .STOP_ON_FAIL(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .dut_d(dut_d), .dut_rst_n(dut_rst_n),
        .dut_q(q_v[1]), .busy(busy_b), .done(done_b), .pass(pass_b), .fail_pulse(fp_b),
        .chk_cnt(chk_b), .err_cnt(err_b), .first_err_vld(vld_b), .first_err_idx(idx_b));

    dff_checker #(.CNT_W(4), .NUM_CHECKS(15), .STOP_ON_FAIL(0)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .dut_d(dut_d), .dut_rst_n(dut_rst_n),
        .dut_q(q_v[2]), .busy(busy_c), .done(done_c), .pass(pass_c), .fail_pulse(fp_c),
        .chk_cnt(chk_c), .err_cnt(err_c), .first_err_vld(vld_c), .first_err_idx(idx_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input int inst, input string tag);
        check({tag, "_busy"}, 32'(busy_v[inst]), 0);
        check({tag, "_done"}, 32'(done_v[inst]), 0);
        check({tag, "_pass"}, 32'(pass_v[inst]), 0);
        check({tag, "_fp"},   32'(fp_v[inst]),   0);
        check({tag, "_chk"},  32'(chk_v[inst]),  0);
        check({tag, "_err"},  32'(err_v[inst]),  0);
        check({tag, "_vld"},  32'(vld_v[inst]),  0);
        check({tag, "_idx"},  32'(idx_v[inst]),  0);
    endtask

    // One run on instance inst. The start edge is edge 0, the PRIME edge is
    // edge 1, and check c happens at edge c+2. edges returns the edge at
    // which done was first seen, or 0 if max_cyc ran out first.
    // Scenarios: 0 = pattern, 1 = stuck-friendly D/reset, 2 = reset during
    // checks 10-12, 3 = as 2 with Q inverted at check 13, 4 = inverted at
    // check 37, 5 = pattern with start pulsed at check 30, 6 = stop at check
    // 50 without cleanup.
    task automatic run(input int inst, input int scen, input int max_cyc,
                       output int edges, output int fp_cnt, output int fp_max);
        int run_len;
        int c;
        edges = 0; fp_cnt = 0; fp_max = 0; run_len = 0;
        @(negedge clk);
        dut_d = 1'b1; dut_rst_n = 1'b1; start_v[inst] = 1'b1;
        for (int k = 1; k <= max_cyc; k++) begin
            c = k - 2;
            @(negedge clk);
            start_v[inst] = (scen == 5 && c == 30);
            flip_v[inst]  = (scen == 3 && c == 13) || (scen == 4 && c == 37);
            case (scen)
                0, 5: begin
                    dut_d     = k[0] ^ k[2];
                    dut_rst_n = !((k % 11) == 4 || (k % 11) == 5);
                end
                2, 3: begin
                    dut_d     = 1'b1;
                    dut_rst_n = !(c >= 10 && c <= 12);
                end
                default: begin
                    dut_d     = 1'b1;
                    dut_rst_n = 1'b1;
                end
            endcase
            @(posedge clk); #1;
            if (fp_v[inst]) begin
                fp_cnt++; run_len++;
                if (run_len > fp_max) fp_max = run_len;
            end else begin
                run_len = 0;
            end
            if (k == 20) check("pass_low_while_busy", 32'(pass_v[inst]), 0);
            if (scen == 6 && c == 50) begin edges = k; break; end
            if (done_v[inst]) begin edges = k; break; end
        end
        if (scen != 6) begin
            @(negedge clk);
            start_v[inst] = 1'b0; flip_v[inst] = 1'b0; dut_rst_n = 1'b1;
        end
    endtask

    initial begin
        int e, fc, fm;
        rst_n = 1'b0; dut_d = 1'b0; dut_rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin start_v[i] = 0; stuck_v[i] = 0; flip_v[i] = 0; end

        // Reset held low with start high: nothing moves.
        start_v[0] = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_zero(0, "rst_hold");
        end
        @(negedge clk); rst_n = 1'b1; dut_rst_n = 1'b1;
        @(posedge clk); #1;
        check("busy_after_start", 32'(busy_v[0]), 1);
        @(negedge clk); start_v[0] = 1'b0; rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        // Correct flop with a varied D / reset pattern.
        run(0, 0, 150, e, fc, fm);
        check("ideal_edges", e, 101);
        check("ideal_chk", 32'(chk_v[0]), 100);
        check("ideal_err", 32'(err_v[0]), 0);
        check("ideal_pass", 32'(pass_v[0]), 1);
        check("ideal_vld", 32'(vld_v[0]), 0);
        check("ideal_busy", 32'(busy_v[0]), 0);
        repeat (3) @(posedge clk);
        #1;
        check("done_hold_chk", 32'(chk_v[0]), 100);
        check("done_hold_done", 32'(done_v[0]), 1);

        // Q stuck at 0 while D=1: every check fails.
        stuck_v[0] = 1'b1;
        run(0, 1, 150, e, fc, fm);
        stuck_v[0] = 1'b0;
        check("stuck_edges", e, 101);
        check("stuck_err", 32'(err_v[0]), 100);
        check("stuck_idx", 32'(idx_v[0]), 0);
        check("stuck_vld", 32'(vld_v[0]), 1);
        check("stuck_pass", 32'(pass_v[0]), 0);
        check("stuck_fp_run", fm, 100);

        // Reset window during checks 10-12: check 13 expects 0, check 14 expects 1.
        run(0, 2, 150, e, fc, fm);
        check("rstwin_err", 32'(err_v[0]), 0);
        check("rstwin_pass", 32'(pass_v[0]), 1);
        run(0, 3, 150, e, fc, fm);
        check("rstwin_flip_err", 32'(err_v[0]), 1);
        check("rstwin_flip_idx", 32'(idx_v[0]), 13);
        check("rstwin_flip_chk", 32'(chk_v[0]), 100);
        check("rstwin_flip_pass", 32'(pass_v[0]), 0);

        // Stop on first failure: a single mismatch at check 37.
        run(1, 4, 150, e, fc, fm);
        check("sof_edges", e, 39);
        check("sof_chk", 32'(chk_v[1]), 38);
        check("sof_err", 32'(err_v[1]), 1);
        check("sof_idx", 32'(idx_v[1]), 37);
        check("sof_fp_cnt", fc, 1);
        @(posedge clk); #1;
        check("sof_fp_low", 32'(fp_v[1]), 0);
        check("sof_done_hold", 32'(done_v[1]), 1);

        // start during RUN is ignored.
        run(0, 5, 150, e, fc, fm);
        check("start_ign_edges", e, 101);
        check("start_ign_chk", 32'(chk_v[0]), 100);
        check("start_ign_err", 32'(err_v[0]), 0);

        // 4-bit counters, Q stuck: err_cnt ends at all-ones.
        stuck_v[2] = 1'b1;
        run(2, 1, 40, e, fc, fm);
        stuck_v[2] = 1'b0;
        check("w4_edges", e, 16);
        check("w4_chk", 32'(chk_v[2]), 15);
        check("w4_err", 32'(err_v[2]), 15);
        check("w4_pass", 32'(pass_v[2]), 0);

        // Asynchronous reset in the middle of check 50.
        stuck_v[0] = 1'b1;
        run(0, 6, 150, e, fc, fm);
        check("abort_at", e, 52);
        check("abort_err_before", 32'(err_v[0]), 51);
        #2 rst_n = 1'b0;
        #1;
        check_zero(0, "abort_a");
        check_zero(1, "abort_b");
        @(negedge clk); stuck_v[0] = 1'b0; start_v[0] = 1'b0; dut_rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_idle_busy", 32'(busy_v[0]), 0);
        check("abort_idle_done", 32'(done_v[0]), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
